// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync, debounce and hold-to-repeat move pulses for the left/right buttons
// Channel 0 is left, channel 1 is right; both share the conflict and game_over suppression.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_left_raw,
   input  logic btn_right_raw,
   input  logic game_over,
   output logic btn_left,
   output logic btn_right,
   output logic move_left,
   output logic move_right
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int TW = $clog2(REPEAT_DELAY);
   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

   logic [1:0]    raw, sync_1, sync_2, level, level_d, lockout, pulse, pulse_nxt, rise;
   logic [DW-1:0] db_cnt [2];
   state_t        state [2];
   state_t        state_nxt [2];
   logic [TW-1:0] timer [2];
   logic [TW-1:0] timer_nxt [2];
   logic          both_held, suppress;

   assign raw       = {btn_right_raw, btn_left_raw};
   assign both_held = &level;
   assign suppress  = game_over | both_held;
   assign rise      = level & ~level_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= '0;
         sync_2 <= '0;
         level  <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         for (int i = 0; i < 2; i++) begin
            if (sync_2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               level[i]  <= sync_2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // A lockout survives until its own button lets go, so the survivor of a conflict stays silent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_d <= '0;
         lockout <= '0;
         pulse   <= '0;
         for (int i = 0; i < 2; i++) begin
            state[i] <= IDLE;
            timer[i] <= '0;
         end
      end else begin
         level_d <= level;
         pulse   <= pulse_nxt;
         for (int i = 0; i < 2; i++) begin
            state[i] <= state_nxt[i];
            timer[i] <= timer_nxt[i];
            if (both_held)
               lockout[i] <= 1'b1;
            else if (!level[i])
               lockout[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_nxt[i] = state[i];
         timer_nxt[i] = timer[i] + TW'(1);
         if (suppress || !level[i]) begin
            state_nxt[i] = IDLE;
            timer_nxt[i] = '0;
         end else begin
            case (state[i])
               IDLE: begin
                  timer_nxt[i] = '0;
                  if (rise[i] && !lockout[i]) state_nxt[i] = DELAY;
               end
               DELAY: begin
                  if (timer[i] == DELAY_LAST) begin
                     state_nxt[i] = REPEAT;
                     timer_nxt[i] = '0;
                  end
               end
               REPEAT: begin
                  if (timer[i] == PERIOD_LAST) timer_nxt[i] = '0;
               end
               default: begin
                  state_nxt[i] = IDLE;
                  timer_nxt[i] = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      pulse_nxt = '0;
      for (int i = 0; i < 2; i++) begin
         if (!suppress && level[i]) begin
            case (state[i])
               IDLE:    pulse_nxt[i] = rise[i] && !lockout[i];
               DELAY:   pulse_nxt[i] = (timer[i] == DELAY_LAST);
               REPEAT:  pulse_nxt[i] = (timer[i] == PERIOD_LAST);
               default: pulse_nxt[i] = 1'b0;
            endcase
         end
      end
   end

   assign btn_left   = level[0];
   assign btn_right  = level[1];
   assign move_left  = pulse[0];
   assign move_right = pulse[1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - bench for button_conditioner with small debounce/repeat parameters
module tb_button_conditioner;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   typedef struct {
      string      name;
      int         cyc;
      logic [3:0] outs;
   } exp_t;

   typedef struct {
      string      name;
      bit         l;
      bit         r;
      bit         go;
      int         len;
      logic [1:0] lv;
      int         nl;
      int         nr;
   } vec_t;

   typedef struct {
      string      name;
      logic [1:0] lv;
      int         el;
      int         er;
   } phase_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic l_raw = 1'b0;
   logic r_raw = 1'b0;
   logic game_over = 1'b0;
   logic btn_left, btn_right, move_left, move_right;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int cnt_l = 0;
   int cnt_r = 0;
   int t, q;

   exp_t   exp_q[$];
   phase_t phase_q[$];
   vec_t   vecs[13];

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_left_raw(l_raw),
      .btn_right_raw(r_raw),
      .game_over(game_over),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .move_left(move_left),
      .move_right(move_right)
   );

   function automatic logic [3:0] cur_outs();
      return {btn_left, btn_right, move_left, move_right};
   endfunction

   function automatic bit rep_pulse(int k);
      return (k == 0) || (k >= RD && ((k - RD) % RP) == 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic push(input string name, input int c, input bit bl, input bit br, input bit ml, input bit mr);
      exp_t e;
      e.name = name;
      e.cyc  = c;
      e.outs = {bl, br, ml, mr};
      exp_q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (move_left) cnt_l++;
      if (move_right) cnt_r++;
      check($sformatf("mutex c%0d", cyc), {31'd0, move_left & move_right}, 32'd0);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         if (e.cyc < cyc)
            check($sformatf("%s stale", e.name), e.cyc, cyc);
         else
            check($sformatf("%s c%0d", e.name, e.cyc), {28'd0, cur_outs()}, {28'd0, e.outs});
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin
      phase_t p;

      vecs[0]  = '{"glitch",     1'b1, 1'b0, 1'b0,  3, 2'b00, 0, 0};
      vecs[1]  = '{"glitch_rel", 1'b0, 1'b0, 1'b0, 10, 2'b00, 0, 0};
      vecs[2]  = '{"hold_l",     1'b1, 1'b0, 1'b0, 30, 2'b10, 6, 0};
      vecs[3]  = '{"rel_l",      1'b0, 1'b0, 1'b0, 20, 2'b00, 2, 0};
      vecs[4]  = '{"tap_r",      1'b0, 1'b1, 1'b0, 12, 2'b01, 0, 1};
      vecs[5]  = '{"rel_r",      1'b0, 1'b0, 1'b0, 12, 2'b00, 0, 1};
      vecs[6]  = '{"both",       1'b1, 1'b1, 1'b0, 15, 2'b11, 0, 0};
      vecs[7]  = '{"rel_both",   1'b0, 1'b0, 1'b0, 10, 2'b00, 0, 0};
      vecs[8]  = '{"go_press",   1'b1, 1'b0, 1'b1, 12, 2'b10, 0, 0};
      vecs[9]  = '{"go_drop",    1'b1, 1'b0, 1'b0, 12, 2'b10, 0, 0};
      vecs[10] = '{"go_rel",     1'b0, 1'b0, 1'b0, 10, 2'b00, 0, 0};
      vecs[11] = '{"go_right",   1'b0, 1'b1, 1'b1, 20, 2'b01, 0, 0};
      vecs[12] = '{"go_rrel",    1'b0, 1'b0, 1'b0, 10, 2'b00, 0, 0};

      // reset state
      for (int c = 1; c <= 3; c++) push("reset", c, 0, 0, 0, 0);
      run(3);
      reset = 1'b0;
      run(2);

      // phase table: levels at the end of each phase and pulse counts inside it
      for (int i = 0; i < 13; i++) begin
         l_raw     = vecs[i].l;
         r_raw     = vecs[i].r;
         game_over = vecs[i].go;
         p.name = vecs[i].name;
         p.lv   = vecs[i].lv;
         p.el   = cnt_l + vecs[i].nl;
         p.er   = cnt_r + vecs[i].nr;
         phase_q.push_back(p);
         run(vecs[i].len);
         p = phase_q.pop_front();
         check({p.name, " levels"}, {30'd0, btn_left, btn_right}, {30'd0, p.lv});
         check({p.name, " left count"}, cnt_l, p.el);
         check({p.name, " right count"}, cnt_r, p.er);
      end
      game_over = 1'b0;

      // clean press and hold with repeat cadence, then release
      t = cyc;
      l_raw = 1'b1;
      for (int c = t + 1; c <= t + 49; c++)
         push("hold", c, (c >= t + 6) && (c < t + 43), 0,
              (c >= t + 7) && (c <= t + 42) && rep_pulse(c - t - 7), 0);
      run(37);
      l_raw = 1'b0;
      run(12);
      run(6);

      // conflict: left held, right joins, right leaves, left re-pressed
      t = cyc;
      l_raw = 1'b1;
      for (int c = t + 1; c <= t + 21; c++)
         push("conf_l", c, c >= t + 6, 0, (c >= t + 7) && rep_pulse(c - t - 7), 0);
      run(21);
      r_raw = 1'b1;
      for (int c = t + 22; c <= t + 40; c++)
         push("conf_both", c, 1, c >= t + 27, (c < t + 27) && rep_pulse(c - t - 7), 0);
      run(19);
      r_raw = 1'b0;
      for (int c = t + 41; c <= t + 60; c++)
         push("conf_relr", c, 1, c < t + 46, 0, 0);
      run(20);
      l_raw = 1'b0;
      for (int c = t + 61; c <= t + 75; c++)
         push("conf_rell", c, c < t + 66, 0, 0, 0);
      run(15);
      q = cyc;
      l_raw = 1'b1;
      for (int c = q + 1; c <= q + 12; c++)
         push("conf_repress", c, c >= q + 6, 0, c == q + 7, 0);
      run(12);
      l_raw = 1'b0;
      run(12);

      // reset while repeating with the button held
      t = cyc;
      l_raw = 1'b1;
      for (int c = t + 1; c <= t + 23; c++)
         push("pre_rst", c, c >= t + 6, 0, (c >= t + 7) && rep_pulse(c - t - 7), 0);
      run(23);
      reset = 1'b1;
      #1;
      check("async reset", {28'd0, cur_outs()}, 32'd0);
      for (int c = t + 24; c <= t + 26; c++) push("in_rst", c, 0, 0, 0, 0);
      run(3);
      reset = 1'b0;
      q = cyc;
      for (int c = q + 1; c <= q + 25; c++)
         push("post_rst", c, c >= q + 6, 0, (c >= q + 7) && rep_pulse(c - q - 7), 0);
      run(25);
      l_raw = 1'b0;
      run(12);

      check("queue drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
